// File: rtl/axil_master_arbiter.sv
// rtl/axil_master_arbiter.sv - round-robin arbiter sharing one AXI4-Lite master among N_REQ requesters
module axil_master_arbiter #(
    parameter int N_REQ   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [N_REQ-1:0]      REQ_VALID,
    input  logic [N_REQ-1:0]      REQ_WRITE,
    input  logic [N_REQ*AW-1:0]   REQ_ADDR,
    input  logic [N_REQ*DW-1:0]   REQ_WDATA,
    input  logic [N_REQ*DW/8-1:0] REQ_WSTRB,
    output logic [N_REQ-1:0]      REQ_READY,
    output logic [N_REQ-1:0]      RSP_VALID,
    output logic [DW-1:0]         RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  BUSY,
    output logic                  TIMEOUT_ERR,
    output logic [AW-1:0]         M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DW-1:0]         M_AXI_WDATA,
    output logic [DW/8-1:0]       M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [AW-1:0]         M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DW-1:0]         M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int SW = DW / 8;
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t         state, state_next;
    logic [GW-1:0]  last_grant, gnt_idx, gnt_sel;
    logic           gnt_found;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [SW-1:0]  wstrb_q;
    logic           aw_done, w_done;
    logic [DW-1:0]  cap_rdata, hold_rdata;
    logic           cap_err, hold_err;
    logic [CW-1:0]  wd_cnt;
    logic           timeout_q;
    logic           aw_hs, w_hs, in_wait;
    logic           unused_resp;

    // Search starts one past the last winner so every requester is served within N_REQ grants.
    always_comb begin
        logic [GW-1:0] idx;
        gnt_found = 1'b0;
        gnt_sel   = '0;
        idx       = last_grant;
        for (int k = 0; k < N_REQ; k++) begin
            if (idx == GW'(N_REQ - 1)) idx = '0;
            else                       idx = idx + GW'(1);
            if (!gnt_found && REQ_VALID[idx]) begin
                gnt_found = 1'b1;
                gnt_sel   = idx;
            end
        end
    end

    assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
    assign in_wait     = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_RESP);
    assign unused_resp = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_found) state_next = REQ_WRITE[gnt_sel] ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
            WR_RESP: if (M_AXI_BVALID) state_next = DONE;
            RD_REQ:  if (M_AXI_ARREADY) state_next = RD_RESP;
            RD_RESP: if (M_AXI_RVALID) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        M_AXI_AWVALID = (state == WR_REQ) && !aw_done;
        M_AXI_WVALID  = (state == WR_REQ) && !w_done;
        M_AXI_BREADY  = (state == WR_RESP);
        M_AXI_ARVALID = (state == RD_REQ);
        M_AXI_RREADY  = (state == RD_RESP);
        BUSY          = (state != IDLE);
        REQ_READY     = '0;
        if (state == IDLE && gnt_found && !ARESET) REQ_READY = N_REQ'(1) << gnt_sel;
        RSP_VALID     = '0;
        if (state == DONE) RSP_VALID = N_REQ'(1) << gnt_idx;
        // Response fields switch only in DONE and then hold until the next completion.
        RSP_RDATA     = (state == DONE) ? cap_rdata : hold_rdata;
        RSP_ERR       = (state == DONE) ? cap_err : hold_err;
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign TIMEOUT_ERR  = timeout_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            last_grant <= GW'(N_REQ - 1);
            gnt_idx    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            cap_rdata  <= '0;
            cap_err    <= 1'b0;
            hold_rdata <= '0;
            hold_err   <= 1'b0;
            wd_cnt     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt_found) begin
                    gnt_idx    <= gnt_sel;
                    last_grant <= gnt_sel;
                    aw_done    <= 1'b0;
                    w_done     <= 1'b0;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (gnt_sel == GW'(i)) begin
                            addr_q  <= REQ_ADDR[i*AW +: AW];
                            wdata_q <= REQ_WDATA[i*DW +: DW];
                            wstrb_q <= REQ_WSTRB[i*SW +: SW];
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                WR_RESP: if (M_AXI_BVALID) begin
                    cap_rdata <= '0;
                    cap_err   <= M_AXI_BRESP[1];
                end
                RD_RESP: if (M_AXI_RVALID) begin
                    cap_rdata <= M_AXI_RDATA;
                    cap_err   <= M_AXI_RRESP[1];
                end
                DONE: begin
                    hold_rdata <= cap_rdata;
                    hold_err   <= cap_err;
                end
                default: ;
            endcase

            // Watchdog only flags a stalled phase; the transaction itself is never abandoned.
            if (state_next != state)           wd_cnt <= '0;
            else if (wd_cnt != CW'(TIMEOUT))   wd_cnt <= wd_cnt + CW'(1);
            if (in_wait && state_next == state && wd_cnt == CW'(TIMEOUT - 1)) timeout_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// tb/tb_axil_master_arbiter.sv - directed self-checking bench for axil_master_arbiter
module tb_axil_master_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          ARESET;
    logic [N-1:0]  REQ_VALID, REQ_WRITE, REQ_READY, RSP_VALID;
    logic [N*32-1:0] REQ_ADDR, REQ_WDATA;
    logic [N*4-1:0]  REQ_WSTRB;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERR, BUSY, TIMEOUT_ERR;
    logic [31:0]   M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]    M_AXI_WSTRB;
    logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
    logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic          M_AXI_RVALID, M_AXI_RREADY;

    axil_master_arbiter #(.N_REQ(N), .AW(32), .DW(32), .TIMEOUT(8)) dut (
        .ACLK(clk), .ARESET(ARESET),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .REQ_READY(REQ_READY),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: memory plus per-channel ready/valid delays, updated on the falling edge.
    logic [31:0] mem [0:63];
    int          aw_delay = 0, b_delay = 0, r_delay = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [3:0]  wr_strb;

    always @(negedge clk) begin
        if (ARESET) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
        end else begin
            if (M_AXI_AWVALID) begin
                M_AXI_AWREADY = (aw_cnt >= aw_delay);
                if (M_AXI_AWREADY) wr_addr = M_AXI_AWADDR;
                aw_cnt++;
            end else begin
                M_AXI_AWREADY = 0; aw_cnt = 0;
            end
            if (M_AXI_WVALID) begin
                M_AXI_WREADY = 1;
                wr_data = M_AXI_WDATA; wr_strb = M_AXI_WSTRB;
                w_cnt++;
            end else begin
                M_AXI_WREADY = 0; w_cnt = 0;
            end
            if (M_AXI_BREADY) begin
                M_AXI_BVALID = (b_cnt >= b_delay);
                M_AXI_BRESP  = bresp_cfg;
                if (M_AXI_BVALID)
                    for (int b = 0; b < 4; b++)
                        if (wr_strb[b]) mem[wr_addr[7:2]][8*b +: 8] = wr_data[8*b +: 8];
                b_cnt++;
            end else begin
                M_AXI_BVALID = 0; b_cnt = 0;
            end
            M_AXI_ARREADY = M_AXI_ARVALID;
            if (M_AXI_ARVALID) rd_addr = M_AXI_ARADDR;
            if (M_AXI_RREADY) begin
                M_AXI_RVALID = (r_cnt >= r_delay);
                M_AXI_RDATA  = mem[rd_addr[7:2]];
                M_AXI_RRESP  = rresp_cfg;
                r_cnt++;
            end else begin
                M_AXI_RVALID = 0; M_AXI_RDATA = 0; r_cnt = 0;
            end
        end
    end

    typedef struct {
        int          id;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp;      // memory word after a write, RSP_RDATA for a read
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic run_txn(input string tag, input vec_t v);
        int cyc;
        bresp_cfg = v.resp;
        rresp_cfg = v.resp;
        @(negedge clk);
        REQ_VALID = '0;
        REQ_VALID[v.id] = 1'b1;
        REQ_WRITE[v.id] = v.wr;
        REQ_ADDR[v.id*32 +: 32]  = v.addr;
        REQ_WDATA[v.id*32 +: 32] = v.wdata;
        REQ_WSTRB[v.id*4 +: 4]   = v.strb;
        #1 check({tag, "_grant"}, REQ_READY, 64'(1 << v.id));
        @(negedge clk);
        REQ_VALID = '0;
        cyc = 1;
        #1;
        while (RSP_VALID == 0 && cyc < 50) begin
            @(negedge clk); #1; cyc++;
        end
        check({tag, "_latency"}, cyc, 3);
        check({tag, "_rsp_onehot"}, RSP_VALID, 64'(1 << v.id));
        check({tag, "_rsp_err"}, RSP_ERR, v.exp_err);
        if (v.wr) begin
            check({tag, "_wr_rdata"}, RSP_RDATA, 0);
            check({tag, "_mem"}, mem[v.addr[7:2]], v.exp);
        end else begin
            check({tag, "_rdata"}, RSP_RDATA, v.exp);
        end
    endtask

    int t, g, aw_hi, w_hi, br_cyc, rsp_cyc;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        vecs[0] = '{0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 2'b00, 32'hA5A5A5A5, 1'b0};
        vecs[1] = '{1, 1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5, 1'b0};
        vecs[2] = '{2, 1'b1, 32'h20, 32'h12345678, 4'h3, 2'b00, 32'h00005678, 1'b0};
        vecs[3] = '{3, 1'b0, 32'h20, 32'h0,        4'h0, 2'b10, 32'h00005678, 1'b1};
        vecs[4] = '{0, 1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hA5A5A5A5, 1'b0};
        vecs[5] = '{1, 1'b1, 32'h24, 32'hDEADBEEF, 4'hC, 2'b10, 32'hDEAD0000, 1'b1};

        ARESET = 1; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", BUSY, 0);
        check("reset_outs", {REQ_READY, RSP_VALID, RSP_ERR, TIMEOUT_ERR}, 0);
        check("reset_rdata", RSP_RDATA, 0);
        ARESET = 0;

        // Round robin with all requesters held active: 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            mem[16+i] = 32'h1000_0000 + i;
            REQ_ADDR[i*32 +: 32] = 32'h40 + 4*i;
        end
        @(negedge clk);
        REQ_WRITE = '0; REQ_VALID = 4'hF;
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            t = 0; #1;
            while (REQ_READY == 0 && t < 20) begin @(negedge clk); #1; t++; end
            check($sformatf("rr%0d_grant", n), REQ_READY, 64'(1 << g));
            t = 0; @(negedge clk); #1;
            while (RSP_VALID == 0 && t < 20) begin @(negedge clk); #1; t++; end
            check($sformatf("rr%0d_rsp", n), RSP_VALID, 64'(1 << g));
            check($sformatf("rr%0d_rdata", n), RSP_RDATA, 32'h1000_0000 + g);
            if (n == 4) REQ_VALID = '0;
        end

        for (int i = 0; i < 6; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // AWREADY held off 3 cycles, WREADY immediate.
        aw_delay = 3; bresp_cfg = 2'b00;
        @(negedge clk);
        REQ_VALID = 4'b0100; REQ_WRITE[2] = 1'b1;
        REQ_ADDR[64 +: 32] = 32'h28; REQ_WDATA[64 +: 32] = 32'h0BADF00D; REQ_WSTRB[8 +: 4] = 4'hF;
        #1 check("aw_delay_grant", REQ_READY, 4'b0100);
        aw_hi = 0; w_hi = 0; br_cyc = 0; rsp_cyc = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) REQ_VALID = '0;
            #1;
            if (M_AXI_AWVALID) aw_hi++;
            if (M_AXI_WVALID) w_hi++;
            if (M_AXI_BREADY && br_cyc == 0) br_cyc = c;
            if (RSP_VALID != 0 && rsp_cyc == 0) rsp_cyc = c;
        end
        check("aw_delay_awvalid_cycles", aw_hi, 4);
        check("aw_delay_wvalid_cycles", w_hi, 1);
        check("aw_delay_bready_cycle", br_cyc, 5);
        check("aw_delay_rsp_cycle", rsp_cyc, 6);
        check("aw_delay_mem", mem[10], 32'h0BADF00D);
        aw_delay = 0;

        // BVALID withheld 20 cycles against TIMEOUT=8.
        check("pre_timeout_flag", TIMEOUT_ERR, 0);
        b_delay = 20;
        @(negedge clk);
        REQ_VALID = 4'b1000; REQ_WRITE[3] = 1'b1;
        REQ_ADDR[96 +: 32] = 32'h2C; REQ_WDATA[96 +: 32] = 32'h55AA55AA; REQ_WSTRB[12 +: 4] = 4'hF;
        #1 check("timeout_grant", REQ_READY, 4'b1000);
        rsp_cyc = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) REQ_VALID = '0;
            #1;
            if (c == 9)  check("timeout_before", TIMEOUT_ERR, 0);
            if (c == 10) check("timeout_set", TIMEOUT_ERR, 1);
            if (RSP_VALID != 0 && rsp_cyc == 0) rsp_cyc = c;
        end
        check("timeout_rsp_cycle", rsp_cyc, 23);
        check("timeout_mem", mem[11], 32'h55AA55AA);
        b_delay = 0;
        run_txn("post_timeout", vecs[1]);
        check("timeout_sticky", TIMEOUT_ERR, 1);

        // Reset during RD_RESP, then requester 0 must win again.
        r_delay = 10; rresp_cfg = 2'b00;
        @(negedge clk);
        REQ_VALID = 4'b0001; REQ_WRITE[0] = 1'b0; REQ_ADDR[31:0] = 32'h10;
        #1 check("rst_mid_grant", REQ_READY, 4'b0001);
        @(negedge clk);
        REQ_VALID = '0;
        t = 0; #1;
        while (!M_AXI_RREADY && t < 20) begin @(negedge clk); #1; t++; end
        check("rst_mid_in_rd_resp", M_AXI_RREADY, 1);
        ARESET = 1;
        @(negedge clk); #1;
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_handshake", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("rst_mid_rsp", {REQ_READY, RSP_VALID, RSP_ERR, TIMEOUT_ERR}, 0);
        check("rst_mid_rdata", RSP_RDATA, 0);
        check("rst_mid_addr", {M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_AWPROT}, 0);
        @(negedge clk); #1;
        ARESET = 0; r_delay = 0;
        REQ_VALID = 4'hF; REQ_WRITE = '0;
        #1 check("rst_first_grant", REQ_READY, 4'b0001);
        @(negedge clk);
        REQ_VALID = '0;
        t = 0; #1;
        while (RSP_VALID == 0 && t < 20) begin @(negedge clk); #1; t++; end
        check("rst_first_rsp", RSP_VALID, 4'b0001);
        check("rst_first_rdata", RSP_RDATA, 32'hA5A5A5A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
